// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: funct codes, FSM states, default latency.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_NOP   = 6'b000000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam int DEFAULT_LATENCY = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_hilo.sv
// HI/LO result register pair: 64-bit write port, 32-bit read port selected by rd_sel (1=HI).
module muldiv_hilo (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic        rd_sel,
    output logic [31:0] rd_data
);

    logic [31:0] hi;
    logic [31:0] lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (wr_en) begin
            hi <= wr_data[63:32];
            lo <= wr_data[31:0];
        end
    end

    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// Controller between issue stage and the fixed-latency multiply/divide datapath.
// Launches ops, counts latency, captures HI/LO, serves MFHI/MFLO with an interlock while busy.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        div_zero,
    output logic [5:0]  unit_funct,
    output logic        unit_start,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [63:0] unit_result
);

    state_t      state;
    state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [5:0]  op_funct;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        launch;
    logic        dz_hit;
    logic        rd_hit;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic [31:0] hilo_rd;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        launch     = 1'b0;
        dz_hit     = 1'b0;
        rd_hit     = 1'b0;
        hilo_we    = 1'b0;
        hilo_wdata = unit_result;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_funct == FUNCT_MULTU ||
                        (req_funct == FUNCT_DIVU && req_b != 32'd0)) begin
                        launch    = 1'b1;
                        state_nxt = ST_RUN;
                    end else if (req_funct == FUNCT_DIVU) begin
                        // Divide-by-zero never reaches the datapath; result is defined here.
                        dz_hit     = 1'b1;
                        hilo_we    = 1'b1;
                        hilo_wdata = {req_a, 32'hFFFF_FFFF};
                    end else if (req_funct == FUNCT_MFHI || req_funct == FUNCT_MFLO) begin
                        rd_hit = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(LATENCY - 1)) begin
                    state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                hilo_we   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_funct  <= FUNCT_NOP;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            div_zero  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state == ST_RUN) ? cnt + 1'b1 : '0;
            rsp_valid <= rd_hit;
            div_zero  <= div_zero | dz_hit;
            if (launch) begin
                op_funct <= req_funct;
                op_a     <= req_a;
                op_b     <= req_b;
            end
            if (rd_hit) begin
                rsp_data <= hilo_rd;
            end
        end
    end

    muldiv_hilo u_hilo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (hilo_we),
        .wr_data (hilo_wdata),
        .rd_sel  (req_funct == FUNCT_MFHI),
        .rd_data (hilo_rd)
    );

    // Busy covers the capture cycle too, so the interlock and unit_funct gating share one term.
    assign busy       = (state != ST_IDLE);
    assign unit_start = (state == ST_RUN) && (cnt == '0);
    assign unit_funct = busy ? op_funct : FUNCT_NOP;
    assign unit_a     = op_a;
    assign unit_b     = op_b;

endmodule
